// File: rtl/addr_reg_file.sv
// Address register file: AR/SP/PCPrev/PC, 8 bits each, with clear/load/dec/inc under per-register enable.
// Write latency 1 cycle, reads combinational; no handshake, so there is no backpressure.
module addr_reg_file (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] i,
  input  logic [1:0] funsel,
  input  logic [3:0] r_sel,
  input  logic [1:0] out_a_sel,
  input  logic [1:0] out_b_sel,
  output logic [7:0] out_a,
  output logic [7:0] out_b
);

  typedef enum logic [1:0] {
    FN_CLR  = 2'b00,
    FN_LOAD = 2'b01,
    FN_DEC  = 2'b10,
    FN_INC  = 2'b11
  } fun_t;

  // Storage is indexed by read-select code: 0 AR, 1 SP, 2 PCPrev, 3 PC.
  logic [3:0][7:0] regs;
  logic [3:0][7:0] nxt;
  logic [3:0]      wr_en;
  fun_t            fun;

  assign fun = fun_t'(funsel);

  // r_sel is MSB-first (bit3 = AR), so it is reversed relative to the storage index.
  assign wr_en = {r_sel[0], r_sel[1], r_sel[2], r_sel[3]};

  always_comb begin
    nxt = regs;
    for (int k = 0; k < 4; k++) begin
      case (fun)
        FN_CLR:  nxt[k] = 8'h00;
        FN_LOAD: nxt[k] = i;
        FN_DEC:  nxt[k] = regs[k] - 8'd1;
        FN_INC:  nxt[k] = regs[k] + 8'd1;
        default: nxt[k] = regs[k];
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      regs <= '0;
    end else begin
      for (int k = 0; k < 4; k++) begin
        if (wr_en[k]) regs[k] <= nxt[k];
      end
    end
  end

  assign out_a = regs[out_a_sel];
  assign out_b = regs[out_b_sel];

endmodule

// File: tb/tb_addr_reg_file.sv
// Bench for addr_reg_file: directed stimulus pushes hand-computed expectations, a monitor pops and compares.
module tb_addr_reg_file;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [7:0] i = 8'h00;
  logic [1:0] funsel = 2'b00;
  logic [3:0] r_sel = 4'b0000;
  logic [1:0] out_a_sel = 2'b00;
  logic [1:0] out_b_sel = 2'b00;
  logic [7:0] out_a;
  logic [7:0] out_b;

  addr_reg_file dut (
    .clk       (clk),
    .rst       (rst),
    .i         (i),
    .funsel    (funsel),
    .r_sel     (r_sel),
    .out_a_sel (out_a_sel),
    .out_b_sel (out_b_sel),
    .out_a     (out_a),
    .out_b     (out_b)
  );

  always #5 clk = ~clk;

  typedef struct {
    string      name;
    logic [7:0] exp_a;
    logic [7:0] exp_b;
  } exp_t;

  exp_t queue_exp[$];
  event chk_ev;
  int   tests_run    = 0;
  int   tests_failed = 0;

  // Monitor: each strobe means the selects are set up; sample slightly later and compare.
  initial begin
    exp_t e;
    forever begin
      @(chk_ev);
      #1;
      if (queue_exp.size() == 0) begin
        tests_run++;
        tests_failed++;
        $display("FAIL %s: strobe with empty scoreboard", "monitor");
      end else begin
        e = queue_exp.pop_front();
        tests_run++;
        if (out_a !== e.exp_a) begin
          tests_failed++;
          $display("FAIL %s out_a: got %h expected %h", e.name, out_a, e.exp_a);
        end
        tests_run++;
        if (out_b !== e.exp_b) begin
          tests_failed++;
          $display("FAIL %s out_b: got %h expected %h", e.name, out_b, e.exp_b);
        end
      end
    end
  end

  task automatic check(input string name, input logic [1:0] sa, input logic [1:0] sb,
                       input logic [7:0] ea, input logic [7:0] eb);
    exp_t e;
    out_a_sel = sa;
    out_b_sel = sb;
    e.name  = name;
    e.exp_a = ea;
    e.exp_b = eb;
    queue_exp.push_back(e);
    -> chk_ev;
    #2;
  endtask

  // Reads all four registers on both ports, port B in reverse order so each port sees every value.
  task automatic check_all(input string name, input logic [7:0] ar, input logic [7:0] sp,
                           input logic [7:0] pp, input logic [7:0] pc);
    check({name, "_ar_pc"}, 2'b00, 2'b11, ar, pc);
    check({name, "_sp_pp"}, 2'b01, 2'b10, sp, pp);
    check({name, "_pp_sp"}, 2'b10, 2'b01, pp, sp);
    check({name, "_pc_ar"}, 2'b11, 2'b00, pc, ar);
  endtask

  // Applies one write edge, then drops r_sel so later checks that span edges cannot disturb state.
  task automatic do_edge(input logic [1:0] fs, input logic [3:0] rs, input logic [7:0] d);
    funsel = fs;
    r_sel  = rs;
    i      = d;
    @(posedge clk);
    #1;
    r_sel  = 4'b0000;
  endtask

  initial begin
    // Async reset with no clock edge: first posedge is at t=5.
    #1;
    rst = 1'b1;
    #1;
    check_all("rst_async", 8'h00, 8'h00, 8'h00, 8'h00);
    @(negedge clk);
    rst = 1'b0;

    do_edge(2'b01, 4'b1111, 8'h5A);
    check_all("load_all", 8'h5A, 8'h5A, 8'h5A, 8'h5A);
    do_edge(2'b00, 4'b1111, 8'hC3);
    check_all("clear_all", 8'h00, 8'h00, 8'h00, 8'h00);

    do_edge(2'b01, 4'b1000, 8'h11);
    check_all("ld_ar", 8'h11, 8'h00, 8'h00, 8'h00);
    do_edge(2'b01, 4'b0100, 8'h22);
    check_all("ld_sp", 8'h11, 8'h22, 8'h00, 8'h00);
    do_edge(2'b01, 4'b0010, 8'h33);
    check_all("ld_pp", 8'h11, 8'h22, 8'h33, 8'h00);
    do_edge(2'b01, 4'b0001, 8'h44);
    check_all("ld_pc", 8'h11, 8'h22, 8'h33, 8'h44);
    check("same_sel", 2'b10, 2'b10, 8'h33, 8'h33);

    do_edge(2'b11, 4'b1010, 8'h00);
    check_all("inc_1010", 8'h12, 8'h22, 8'h34, 8'h44);
    do_edge(2'b01, 4'b0001, 8'hFF);
    do_edge(2'b11, 4'b0001, 8'h00);
    check_all("inc_wrap", 8'h12, 8'h22, 8'h34, 8'h00);

    do_edge(2'b01, 4'b0100, 8'h02);
    check_all("ld_sp02", 8'h12, 8'h02, 8'h34, 8'h00);
    do_edge(2'b10, 4'b0101, 8'h00);
    check_all("dec_1", 8'h12, 8'h01, 8'h34, 8'hFF);
    do_edge(2'b10, 4'b0101, 8'h00);
    do_edge(2'b10, 4'b0101, 8'h00);
    check_all("dec_3", 8'h12, 8'hFF, 8'h34, 8'hFD);

    for (int k = 0; k < 5; k++) do_edge(2'(k), 4'b0000, 8'hA5);
    check_all("hold", 8'h12, 8'hFF, 8'h34, 8'hFD);
    check("ports_indep", 2'b01, 2'b11, 8'hFF, 8'hFD);

    do_edge(2'b11, 4'b1111, 8'h00);
    check_all("inc_all_1", 8'h13, 8'h00, 8'h35, 8'hFE);
    do_edge(2'b11, 4'b1111, 8'h00);
    // Reset lands 1 time unit after the edge, well before the next one.
    rst = 1'b1;
    #1;
    check_all("rst_mid", 8'h00, 8'h00, 8'h00, 8'h00);
    do_edge(2'b11, 4'b1111, 8'h00);
    check_all("rst_held", 8'h00, 8'h00, 8'h00, 8'h00);
    @(negedge clk);
    rst = 1'b0;
    do_edge(2'b11, 4'b1111, 8'h00);
    check_all("post_rst_inc", 8'h01, 8'h01, 8'h01, 8'h01);

    for (int k = 0; k < 100 && queue_exp.size() != 0; k++) #1;
    if (queue_exp.size() != 0) begin
      tests_run++;
      tests_failed++;
      $display("FAIL drain: %0d entries left, expected 0", queue_exp.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
